// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ==========================================================================
// hazard_scoreboard : E-stage forwarding, load-use/multi-cycle stall control,
//                     branch flush and saturating stall/flush counters.
// Rev 1.0
// ==========================================================================
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 8,
  parameter int LW      = $clog2(MAX_LAT + 1),
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UseRs1D,
  input  logic              UseRs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              LongStartE,
  input  logic [LW-1:0]     LongLatE,
  input  logic              ClearCnt,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              BusyE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0]     C_MAX_LAT = LW'(MAX_LAT);
  localparam logic [LW-1:0]     C_ONE     = LW'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    eff_lat, lat_m1, cnt_dec;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall, long_go, busy;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && RegWriteE && (RdE != '0) &&
                    ((UseRs1D && (Rs1D == RdE)) || (UseRs2D && (Rs2D == RdE)));

  always_comb begin
    eff_lat = LongLatE;
    if (LongLatE == '0)            eff_lat = C_ONE;
    else if (LongLatE > C_MAX_LAT) eff_lat = C_MAX_LAT;
  end

  assign lat_m1  = eff_lat - C_ONE;
  assign cnt_dec = cnt_q - C_ONE;
  assign long_go = LongStartE && (eff_lat > C_ONE);
  // The IDLE cycle that accepts the op is itself the first stall cycle.
  assign busy    = reset && ((state_q == BUSY) || ((state_q == IDLE) && long_go));

  // cnt counts down to 1; the edge that would register 1 moves the FSM to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (long_go) begin
          cnt_d   = lat_m1;
          state_d = (lat_m1 == C_ONE) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_dec;
        if (cnt_dec == C_ONE) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign BusyE  = busy;
  assign StallE = busy;
  assign FlushM = busy;
  assign StallF = busy || lw_stall;
  assign StallD = busy || lw_stall;
  assign FlushE = !busy && (lw_stall || PCSrcE);
  assign FlushD = !busy && PCSrcE;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ClearCnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != C_CNT_MAX)) stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      if (FlushD && (flush_cnt_q != C_CNT_MAX)) flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
`default_nettype wire
